rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
- Parametrised successor of the SPU 128x128 register file.
- Configurable data width, depth, and read/write port counts.
- Write-port priority and enable-qualified same-cycle bypass.
- Sequential zero-initialisation sweep plus a valid/ready preload channel, so the array needs no reset fan-out. Sits between decode/operand fetch and the even/odd pipe writeback stages.

Parameters:
- DATA_W, 128, register width in bits
- DEPTH, 128, number of registers; power of two, at least 2
- AW, $clog2(DEPTH), address width (derived)
- NUM_RD, 6, read ports
- NUM_WR, 2, write ports

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses; port k occupies slice k
- wr_data  in  NUM_WR*DATA_W  write data per port
- rd_addr  in  NUM_RD*AW  read addresses per port
- rd_data  out  NUM_RD*DATA_W  read data per port
- preload_mode  in  1  sampled at end of INIT; 1 selects LOAD, 0 selects RUN
- preload_valid  in  1  preload beat valid
- preload_ready  out  1  preload beat accepted when valid && ready
- preload_addr  in  AW  preload target register
- preload_data  in  DATA_W  preload value
- preload_last  in  1  marks the final preload beat
- rf_ready  out  1  high only in RUN
- wr_conflict  out  1  sticky conflict flag; exists only with RF_CONFLICT_DET_EN

Behaviour:
- FSM states are INIT, LOAD and RUN. Async rst forces INIT with init_cnt=0.
- Reset values: rf_ready=0, preload_ready=0, wr_conflict=0.
- The storage array itself is not reset.
- INIT:
  - Each cycle writes 0 to reg[init_cnt], then increments init_cnt.
  - When init_cnt==DEPTH-1, that cycle's write completes and the next state is LOAD if preload_mode=1, else RUN.
  - INIT lasts exactly DEPTH cycles.
  - wr_en is ignored. rd_data is forced to 0.
- LOAD:
  - preload_ready=1.
  - An accepted beat writes preload_data to reg[preload_addr] at the clock edge.
  - An accepted beat with preload_last=1 moves to RUN on the same edge.
  - preload_valid=0 means the block holds in LOAD indefinitely.
  - wr_en is ignored. Reads return array contents, with no bypass from preload.
- RUN:
  - rf_ready=1, preload_ready=0. Preload inputs are ignored.
  - Writes are synchronous: reg[wr_addr[k]] <= wr_data[k] for each k with wr_en[k]=1.
  - If several enabled ports target the same address, the highest port index wins.
- Reads are combinational, with zero-cycle latency in LOAD and RUN.
- Bypass, RUN only:
  - For read port j, the candidates are enabled write ports with wr_addr[k]==rd_addr[j].
  - rd_data[j] takes the wr_data of the highest-index candidate.
  - With no candidate, rd_data[j] takes reg[rd_addr[j]].
  - A disabled write port never forwards, even on an address match.
- Address range: addresses are AW bits wide. With DEPTH a power of two every address is in range, so there is no wrap-around case.
- Reset asserted mid-LOAD or mid-RUN:
  - Returns immediately to INIT.
  - Array contents are overwritten by the sweep.
  - A partially delivered preload is discarded; the source must restart.

Optional Feature:
- Macro: RF_CONFLICT_DET_EN.
- Defined:
  - The wr_conflict port exists.
  - It is set on any RUN-state clock edge where two or more enabled write ports share an address.
  - It stays set until rst. Write resolution is unchanged (highest index wins).
- Undefined: the port and its logic are absent, and conflicts resolve silently.

Decomposition:
- Shared package spu_rf_pkg holds:
  - the FSM state enum rf_state_t (INIT, LOAD, RUN);
  - default constants RF_DATA_W=128, RF_DEPTH=128, RF_NUM_RD=6, RF_NUM_WR=2.
- One sub-module, rf_bypass_mux:
  - One instance per read port.
  - Takes one rd_addr, the stored word, and all write ports.
  - Returns priority-resolved read data.
- The FSM, init counter and array stay in the top module.

Test Plan:
- Reset, preload_mode=0: rf_ready rises exactly 128 cycles after rst falls. All 128 registers read 0; rd_data=0 throughout INIT.
- preload_mode=1, beats (5, 0xAA..AA) then (127, 0x1234, last=1), with preload_valid gapped every other cycle:
  - Only valid&&ready beats land.
  - Then rf_ready=1, rd r5=0xAA..AA, rd r127=0x1234.
- RUN, wr_en=2'b11 with both ports at address 9, data0=1 and data1=2:
  - Same-cycle read of r9 on all six ports returns 2.
  - Next cycle r9=2.
  - With the macro defined, wr_conflict=1 and stays 1.
- RUN, wr_en=2'b00, wr_addr0=rd_addr0=3, wr_data0=0xFF, r3 holds 7: rd_data0=7 (no forward). Next cycle still 7.
- RUN, write port 0 to r10 with 0x55: same-cycle read of r10 returns 0x55, and r10 holds 0x55 afterwards.
- rst pulsed mid-LOAD after 3 beats: returns to INIT, preload_ready=0 for 128 cycles, all prior preloaded registers read 0 afterwards.

Source files
------------

// File: rtl/spu_rf_pkg.sv
// Shared types and default sizing for the SPU multiport register file.
package spu_rf_pkg;

  localparam int RF_DATA_W = 128;
  localparam int RF_DEPTH  = 128;
  localparam int RF_NUM_RD = 6;
  localparam int RF_NUM_WR = 2;

  // INIT sweeps zeros, LOAD accepts preload beats, RUN is normal operation.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } rf_state_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port forwarding mux: picks the highest-index enabled write port
// whose address matches, otherwise passes the stored word through.
module rf_bypass_mux #(
  parameter int DATA_W = 128,
  parameter int AW     = 7,
  parameter int NUM_WR = 2
) (
  input  logic                     bypass_en_i,
  input  logic [AW-1:0]            rd_addr_i,
  input  logic [DATA_W-1:0]        stored_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  // Ascending scan so a later (higher-index) match overrides an earlier one.
  always_comb begin
    rd_data_o = stored_i;
    for (int k = 0; k < NUM_WR; k++) begin
      if (bypass_en_i && wr_en_i[k] && (wr_addr_i[k*AW +: AW] == rd_addr_i)) begin
        rd_data_o = wr_data_i[k*DATA_W +: DATA_W];
      end else begin
        rd_data_o = rd_data_o;
      end
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multiport register file with zero-init sweep and preload
// channel. Optional sticky write-conflict flag under RF_CONFLICT_DET_EN.
module rf_multiport
  import spu_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int AW     = $clog2(DEPTH),
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     preload_mode,
  input  logic                     preload_valid,
  output logic                     preload_ready,
  input  logic [AW-1:0]            preload_addr,
  input  logic [DATA_W-1:0]        preload_data,
  input  logic                     preload_last,
`ifdef RF_CONFLICT_DET_EN
  output logic                     wr_conflict,
`endif
  output logic                     rf_ready
);

  rf_state_t         state_q, state_d;
  logic [AW-1:0]     init_cnt_q, init_cnt_d;
  logic              rf_ready_q;
  logic              preload_ready_q;
  logic              preload_fire_s;
  logic              bypass_en_s;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign preload_fire_s = preload_ready_q && preload_valid;
  assign bypass_en_s    = (state_q == RUN);
  assign rf_ready       = rf_ready_q;
  assign preload_ready  = preload_ready_q;

  // Next-state and init counter: sweep DEPTH entries, then branch on preload_mode.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(DEPTH - 1)) begin
          if (preload_mode) begin
            state_d = LOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = INIT;
        end
      end
      LOAD: begin
        if (preload_fire_s && preload_last) begin
          state_d = RUN;
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d    = INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  // State register plus handshake/ready flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= INIT;
      init_cnt_q      <= '0;
      rf_ready_q      <= 1'b0;
      preload_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      rf_ready_q      <= (state_d == RUN);
      preload_ready_q <= (state_d == LOAD);
    end
  end

  // Storage array, deliberately unreset: the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    case (state_q)
      INIT: begin
        mem_q[init_cnt_q] <= '0;
      end
      LOAD: begin
        if (preload_fire_s) begin
          mem_q[preload_addr] <= preload_data;
        end
      end
      RUN: begin
        // Later loop iterations override earlier ones: highest port wins.
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k]) begin
            mem_q[wr_addr[k*AW +: AW]] <= wr_data[k*DATA_W +: DATA_W];
          end
        end
      end
      default: begin
      end
    endcase
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [AW-1:0]     addr_s;
    logic [DATA_W-1:0] mux_s;

    assign addr_s = rd_addr[j*AW +: AW];

    rf_bypass_mux #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .bypass_en_i (bypass_en_s),
      .rd_addr_i   (addr_s),
      .stored_i    (mem_q[addr_s]),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .rd_data_o   (mux_s)
    );

    // Array contents are not meaningful until the sweep finishes.
    assign rd_data[j*DATA_W +: DATA_W] = (state_q == INIT) ? '0 : mux_s;
  end

`ifdef RF_CONFLICT_DET_EN
  logic conflict_s;
  logic wr_conflict_q;

  // Any pair of enabled write ports aiming at the same register.
  always_comb begin
    conflict_s = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      for (int m = k + 1; m < NUM_WR; m++) begin
        conflict_s = conflict_s | (wr_en[k] && wr_en[m] &&
                                   (wr_addr[k*AW +: AW] == wr_addr[m*AW +: AW]));
      end
    end
  end

  // Sticky flag, cleared only by reset; counts conflicts only in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_conflict_q <= 1'b0;
    end else if ((state_q == RUN) && conflict_s) begin
      wr_conflict_q <= 1'b1;
    end else begin
      wr_conflict_q <= wr_conflict_q;
    end
  end

  assign wr_conflict = wr_conflict_q;
`endif

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (default parameters).
module tb_rf_multiport;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 128;
  localparam int AW     = 7;
  localparam int NUM_RD = 6;
  localparam int NUM_WR = 2;
  localparam int CW     = NUM_RD * DATA_W;

  logic                     clk_s = 1'b0;
  logic                     rst_s;
  logic [NUM_WR-1:0]        wr_en_s;
  logic [NUM_WR*AW-1:0]     wr_addr_s;
  logic [NUM_WR*DATA_W-1:0] wr_data_s;
  logic [NUM_RD*AW-1:0]     rd_addr_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic                     preload_mode_s;
  logic                     preload_valid_s;
  logic                     preload_ready_s;
  logic [AW-1:0]            preload_addr_s;
  logic [DATA_W-1:0]        preload_data_s;
  logic                     preload_last_s;
  logic                     rf_ready_s;
`ifdef RF_CONFLICT_DET_EN
  logic                     wr_conflict_s;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int cnt;

  rf_multiport dut (
    .clk           (clk_s),
    .rst           (rst_s),
    .wr_en         (wr_en_s),
    .wr_addr       (wr_addr_s),
    .wr_data       (wr_data_s),
    .rd_addr       (rd_addr_s),
    .rd_data       (rd_data_s),
    .preload_mode  (preload_mode_s),
    .preload_valid (preload_valid_s),
    .preload_ready (preload_ready_s),
    .preload_addr  (preload_addr_s),
    .preload_data  (preload_data_s),
    .preload_last  (preload_last_s),
`ifdef RF_CONFLICT_DET_EN
    .wr_conflict   (wr_conflict_s),
`endif
    .rf_ready      (rf_ready_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic set_rd(input int j, input int addr);
    rd_addr_s[j*AW +: AW] = AW'(addr);
  endtask

  task automatic set_rd_all(input int addr);
    for (int j = 0; j < NUM_RD; j++) rd_addr_s[j*AW +: AW] = AW'(addr);
  endtask

  task automatic set_wr(input int k, input logic en, input int addr, input logic [DATA_W-1:0] data);
    wr_en_s[k]                    = en;
    wr_addr_s[k*AW +: AW]         = AW'(addr);
    wr_data_s[k*DATA_W +: DATA_W] = data;
  endtask

  task automatic beat(input logic v, input int addr, input logic [DATA_W-1:0] data, input logic last);
    preload_valid_s = v;
    preload_addr_s  = AW'(addr);
    preload_data_s  = data;
    preload_last_s  = last;
  endtask

  function automatic logic [DATA_W-1:0] rd_port(input int j);
    return rd_data_s[j*DATA_W +: DATA_W];
  endfunction

  initial begin
    rst_s           = 1'b1;
    wr_en_s         = '0;
    wr_addr_s       = '0;
    wr_data_s       = '0;
    rd_addr_s       = '0;
    preload_mode_s  = 1'b0;
    preload_valid_s = 1'b0;
    preload_addr_s  = '0;
    preload_data_s  = '0;
    preload_last_s  = 1'b0;
    for (int j = 0; j < NUM_RD; j++) set_rd(j, 17 * j + 3);

    // ---------------- reset state, INIT length with preload_mode=0
    tick(); tick();
    check_eq("rst_rf_ready", CW'(rf_ready_s), CW'(1'b0));
    check_eq("rst_preload_ready", CW'(preload_ready_s), CW'(1'b0));
`ifdef RF_CONFLICT_DET_EN
    check_eq("rst_wr_conflict", CW'(wr_conflict_s), CW'(1'b0));
`endif
    rst_s = 1'b0;
    cnt = 0;
    while (!rf_ready_s && cnt < 300) begin
      check_eq("init_rd_zero", rd_data_s, '0);
      tick();
      cnt++;
    end
    check_eq("init_len_run", CW'(cnt), CW'(128));
    check_eq("run_preload_ready", CW'(preload_ready_s), CW'(1'b0));
    for (int a = 0; a < DEPTH; a++) begin
      set_rd_all(a);
      #1;
      check_eq("swept_zero", rd_data_s, '0);
    end

    // ---------------- preload with gapped valid
    rst_s = 1'b1;
    tick();
    preload_mode_s = 1'b1;
    rst_s = 1'b0;
    cnt = 0;
    while (!preload_ready_s && cnt < 300) begin
      tick();
      cnt++;
    end
    check_eq("init_len_load", CW'(cnt), CW'(128));
    check_eq("load_rf_ready", CW'(rf_ready_s), CW'(1'b0));
    set_rd(0, 5);
    beat(1'b1, 5, {16{8'hAA}}, 1'b0);
    #1;
    check_eq("load_no_bypass", CW'(rd_port(0)), '0);
    tick();
    beat(1'b0, 6, 128'hDEAD, 1'b1);
    #1;
    check_eq("load_r5_landed", CW'(rd_port(0)), CW'({16{8'hAA}}));
    tick();
    check_eq("gap_stays_load", CW'(preload_ready_s), CW'(1'b1));
    beat(1'b1, 127, 128'h1234, 1'b1);
    tick();
    check_eq("last_rf_ready", CW'(rf_ready_s), CW'(1'b1));
    check_eq("last_preload_ready", CW'(preload_ready_s), CW'(1'b0));
    // Preload inputs must be ignored in RUN.
    beat(1'b1, 8, 128'h99, 1'b0);
    tick();
    beat(1'b0, 0, '0, 1'b0);
    set_rd(0, 5); set_rd(1, 127); set_rd(2, 6); set_rd(3, 8);
    #1;
    check_eq("pre_r5", CW'(rd_port(0)), CW'({16{8'hAA}}));
    check_eq("pre_r127", CW'(rd_port(1)), CW'(128'h1234));
    check_eq("pre_gap_r6", CW'(rd_port(2)), '0);
    check_eq("run_ignores_preload", CW'(rd_port(3)), '0);

    // ---------------- same-address write conflict, highest port wins
`ifdef RF_CONFLICT_DET_EN
    check_eq("no_conflict_yet", CW'(wr_conflict_s), CW'(1'b0));
`endif
    set_wr(0, 1'b1, 9, 128'h1);
    set_wr(1, 1'b1, 9, 128'h2);
    set_rd_all(9);
    #1;
    for (int j = 0; j < NUM_RD; j++) check_eq($sformatf("conf_byp_p%0d", j), CW'(rd_port(j)), CW'(128'h2));
    tick();
    wr_en_s = '0;
    #1;
    check_eq("conf_r9_next", CW'(rd_port(3)), CW'(128'h2));
`ifdef RF_CONFLICT_DET_EN
    check_eq("conflict_set", CW'(wr_conflict_s), CW'(1'b1));
    tick();
    check_eq("conflict_sticky", CW'(wr_conflict_s), CW'(1'b1));
`endif

    // ---------------- disabled port never forwards
    set_wr(1, 1'b1, 3, 128'h7);
    tick();
    set_wr(1, 1'b0, 0, '0);
    set_wr(0, 1'b0, 3, 128'hFF);
    set_rd(0, 3);
    #1;
    check_eq("dis_no_fwd", CW'(rd_port(0)), CW'(128'h7));
    tick();
    check_eq("dis_no_write", CW'(rd_port(0)), CW'(128'h7));

    // ---------------- single-port bypass and write
    set_wr(0, 1'b1, 10, 128'h55);
    set_rd(0, 10);
    #1;
    check_eq("byp_r10", CW'(rd_port(0)), CW'(128'h55));
    tick();
    wr_en_s = '0;
    #1;
    check_eq("wr_r10", CW'(rd_port(0)), CW'(128'h55));

    // ---------------- two ports, different addresses, crossed read ports
    set_wr(0, 1'b1, 20, 128'hA0A0);
    set_wr(1, 1'b1, 21, 128'hB1B1);
    set_rd(4, 20); set_rd(5, 21);
    #1;
    check_eq("byp2_p4", CW'(rd_port(4)), CW'(128'hA0A0));
    check_eq("byp2_p5", CW'(rd_port(5)), CW'(128'hB1B1));
    tick();
    wr_en_s = '0;
    #1;
    check_eq("wr2_r20", CW'(rd_port(4)), CW'(128'hA0A0));
    check_eq("wr2_r21", CW'(rd_port(5)), CW'(128'hB1B1));

    // ---------------- reset mid-LOAD discards partial preload
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    cnt = 0;
    while (!preload_ready_s && cnt < 300) begin
      tick();
      cnt++;
    end
    check_eq("init_len_load2", CW'(cnt), CW'(128));
    beat(1'b1, 5, 128'h11, 1'b0); tick();
    beat(1'b1, 6, 128'h22, 1'b0); tick();
    beat(1'b1, 7, 128'h33, 1'b0); tick();
    beat(1'b0, 0, '0, 1'b0);
    set_rd(0, 6);
    #1;
    check_eq("load_r6_before_rst", CW'(rd_port(0)), CW'(128'h22));
    rst_s = 1'b1;
    #1;
    check_eq("rst_async_pr", CW'(preload_ready_s), CW'(1'b0));
    tick();
    rst_s = 1'b0;
    for (int j = 0; j < NUM_RD; j++) set_rd(j, 5 + (j % 3));
    cnt = 0;
    while (!preload_ready_s && cnt < 300) begin
      check_eq("reinit_rd_zero", rd_data_s, '0);
      tick();
      cnt++;
    end
    check_eq("reinit_len", CW'(cnt), CW'(128));
    #1;
    check_eq("reinit_r5", CW'(rd_port(0)), '0);
    check_eq("reinit_r6", CW'(rd_port(1)), '0);
    check_eq("reinit_r7", CW'(rd_port(2)), '0);
    beat(1'b1, 0, 128'h1, 1'b1);
    tick();
    beat(1'b0, 0, '0, 1'b0);
    check_eq("reload_run", CW'(rf_ready_s), CW'(1'b1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
